// File: rtl/hitskip_ctrl.sv
// Hit-rate monitor for a TDC channel group: drives enable_hitskip with hysteresis
// and thins the hit stream to 1 of every SKIP_N+1 hits while skip mode is active.
module hitskip_ctrl #(
   parameter int CNT_W  = 16,
   parameter int SKIP_W = 4,
   parameter int STAT_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cfg_wr,
   input  logic [1:0]        cfg_addr,
   input  logic [CNT_W-1:0]  cfg_wdata,
   output logic              cfg_ack,
   input  logic              hit_valid,
   output logic              hit_accept,
   output logic              enable_hitskip,
   output logic [STAT_W-1:0] skip_count,
   output logic [1:0]        dbg_state
);

   // Config protocol: cfg_wr is a single-cycle strobe with no back-pressure; the
   // addressed register updates on the edge that samples it and cfg_ack pulses
   // for exactly the following cycle. hit_valid is likewise a one-cycle strobe.

   localparam logic [1:0] ADDR_CTRL   = 2'd0;
   localparam logic [1:0] ADDR_WINDOW = 2'd1;
   localparam logic [1:0] ADDR_TON    = 2'd2;
   localparam logic [1:0] ADDR_TOFF   = 2'd3;
   localparam int         CLR_BIT     = 15;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_MONITOR  = 2'd1,
      ST_SKIPPING = 2'd2
   } state_t;

   state_t              state, state_next;
   logic                ctrl_en;
   logic                ctrl_force;
   logic [SKIP_W-1:0]   skip_n;
   logic [CNT_W-1:0]    window;
   logic [CNT_W-1:0]    thresh_on;
   logic [CNT_W-1:0]    thresh_off;
   logic [CNT_W-1:0]    win_cnt;
   logic [CNT_W-1:0]    hit_cnt;
   logic [SKIP_W-1:0]   phase;

   logic                active;
   logic [CNT_W-1:0]    win_last;
   logic                window_end;
   logic [CNT_W:0]      hit_sum;
   logic [CNT_W-1:0]    hit_final;
   logic                pass;
   logic                drop;
   logic                clr_stat;

   assign dbg_state = state;

   always_comb begin
      active     = (state != ST_IDLE);
      // A programmed window of 0 behaves as a window of 1 cycle.
      win_last   = (window == '0) ? '0 : window - CNT_W'(1);
      window_end = active && (win_cnt == win_last) && !cfg_wr;
      hit_sum    = {1'b0, hit_cnt} + {{CNT_W{1'b0}}, hit_valid};
      hit_final  = hit_sum[CNT_W] ? {CNT_W{1'b1}} : hit_sum[CNT_W-1:0];
      pass       = (state == ST_IDLE) || !enable_hitskip || (phase == '0);
      drop       = hit_valid && !pass;
      clr_stat   = cfg_wr && (cfg_addr == ADDR_CTRL) && cfg_wdata[CLR_BIT];
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: begin
            if (ctrl_en) state_next = ST_MONITOR;
         end
         ST_MONITOR: begin
            if (!ctrl_en)
               state_next = ST_IDLE;
            else if (window_end && (hit_final >= thresh_on))
               state_next = ST_SKIPPING;
         end
         ST_SKIPPING: begin
            if (!ctrl_en)
               state_next = ST_IDLE;
            else if (window_end && (hit_final < thresh_off))
               state_next = ST_MONITOR;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctrl_en    <= 1'b0;
         ctrl_force <= 1'b0;
         skip_n     <= '0;
         window     <= CNT_W'(1000);
         thresh_on  <= CNT_W'(100);
         thresh_off <= CNT_W'(50);
         cfg_ack    <= 1'b0;
      end else begin
         cfg_ack <= cfg_wr;
         if (cfg_wr) begin
            case (cfg_addr)
               ADDR_CTRL: begin
                  ctrl_en    <= cfg_wdata[0];
                  ctrl_force <= cfg_wdata[1];
                  skip_n     <= cfg_wdata[SKIP_W+3:4];
               end
               ADDR_WINDOW: window     <= cfg_wdata;
               ADDR_TON:    thresh_on  <= cfg_wdata;
               ADDR_TOFF:   thresh_off <= cfg_wdata;
               default:     ;
            endcase
         end
      end
   end

   // Any config write restarts the measurement window without touching the state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         win_cnt <= '0;
         hit_cnt <= '0;
      end else if (cfg_wr || !active || window_end) begin
         win_cnt <= '0;
         hit_cnt <= '0;
      end else begin
         win_cnt <= win_cnt + CNT_W'(1);
         hit_cnt <= hit_final;
      end
   end

   // Phase sits at 0 whenever skip mode is off, so every entry starts by passing a hit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase <= '0;
      end else if (!active || !enable_hitskip) begin
         phase <= '0;
      end else if (hit_valid) begin
         phase <= (phase >= skip_n) ? '0 : phase + SKIP_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         enable_hitskip <= 1'b0;
         hit_accept     <= 1'b0;
      end else begin
         enable_hitskip <= (state == ST_SKIPPING) || (ctrl_en && ctrl_force);
         hit_accept     <= hit_valid && pass;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         skip_count <= '0;
      end else if (clr_stat) begin
         skip_count <= '0;
      end else if (drop && (skip_count != {STAT_W{1'b1}})) begin
         skip_count <= skip_count + STAT_W'(1);
      end
   end

endmodule

// File: tb/tb_hitskip_ctrl.sv
// Directed bench for hitskip_ctrl: transparency, rate hysteresis, skip ratio,
// window boundaries, force, clear and asynchronous reset.
module tb_hitskip_ctrl;

   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_MONITOR  = 2'd1;
   localparam logic [1:0] ST_SKIPPING = 2'd2;
   localparam int         WIN         = 100;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        cfg_wr = 1'b0;
   logic [1:0]  cfg_addr = 2'd0;
   logic [15:0] cfg_wdata = 16'd0;
   logic        cfg_ack;
   logic        hit_valid = 1'b0;
   logic        hit_accept;
   logic        enable_hitskip;
   logic [15:0] skip_count;
   logic [1:0]  dbg_state;

   int   n_tests = 0;
   int   n_fail  = 0;
   logic first_ehs;

   hitskip_ctrl #(.CNT_W(16), .SKIP_W(4), .STAT_W(16)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .cfg_wr         (cfg_wr),
      .cfg_addr       (cfg_addr),
      .cfg_wdata      (cfg_wdata),
      .cfg_ack        (cfg_ack),
      .hit_valid      (hit_valid),
      .hit_accept     (hit_accept),
      .enable_hitskip (enable_hitskip),
      .skip_count     (skip_count),
      .dbg_state      (dbg_state)
   );

   // clock / reset
   always #5 clk = ~clk;

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cfg_write(input logic [1:0] a, input logic [15:0] d, input logic hv);
      cfg_wr    = 1'b1;
      cfg_addr  = a;
      cfg_wdata = d;
      hit_valid = hv;
      tick();
      n_tests++;
      if (cfg_ack !== 1'b1) begin n_fail++; $display("FAIL cfg_ack: got %b expected 1", cfg_ack); end
      cfg_wr    = 1'b0;
      hit_valid = 1'b0;
   endtask

   task automatic run_window(input int nhits, input bit last_hit);
      for (int i = 0; i < WIN; i++) begin
         hit_valid = (i < nhits) || (last_hit && (i == WIN - 1));
         tick();
         if (i == 0) first_ehs = enable_hitskip;
      end
      hit_valid = 1'b0;
   endtask

   task automatic test_reset();
      #2 rst_n = 1'b0;
      tick();
      tick();
      n_tests++;
      if ({hit_accept, enable_hitskip, cfg_ack} !== 3'b000) begin
         n_fail++; $display("FAIL reset_flags: got %b expected 000", {hit_accept, enable_hitskip, cfg_ack});
      end
      n_tests++;
      if (skip_count !== 16'd0) begin n_fail++; $display("FAIL reset_skip_count: got %0d expected 0", skip_count); end
      n_tests++;
      if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, ST_IDLE); end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_transparent();
      for (int i = 0; i < 21; i++) begin
         hit_valid = (i < 20);
         tick();
         n_tests++;
         if (hit_accept !== (i < 20)) begin
            n_fail++; $display("FAIL idle_mirror[%0d]: got %b expected %b", i, hit_accept, (i < 20));
         end
      end
      n_tests++;
      if (enable_hitskip !== 1'b0) begin n_fail++; $display("FAIL idle_ehs: got %b expected 0", enable_hitskip); end
      n_tests++;
      if (skip_count !== 16'd0) begin n_fail++; $display("FAIL idle_skip_count: got %0d expected 0", skip_count); end
   endtask

   task automatic test_enter_skip();
      cfg_write(2'd1, 16'd100, 1'b0);
      cfg_write(2'd2, 16'd40, 1'b0);
      cfg_write(2'd3, 16'd20, 1'b0);
      cfg_write(2'd0, 16'h0001, 1'b0);
      tick();
      n_tests++;
      if (dbg_state !== ST_MONITOR) begin n_fail++; $display("FAIL enter_monitor: got %0d expected %0d", dbg_state, ST_MONITOR); end
      run_window(50, 1'b0);
      n_tests++;
      if (dbg_state !== ST_SKIPPING) begin n_fail++; $display("FAIL enter_skipping: got %0d expected %0d", dbg_state, ST_SKIPPING); end
      n_tests++;
      if (enable_hitskip !== 1'b0) begin n_fail++; $display("FAIL ehs_at_window_end: got %b expected 0", enable_hitskip); end
      run_window(50, 1'b0);
      n_tests++;
      if (first_ehs !== 1'b1) begin n_fail++; $display("FAIL ehs_rise: got %b expected 1", first_ehs); end
      n_tests++;
      if ({dbg_state, enable_hitskip} !== {ST_SKIPPING, 1'b1}) begin
         n_fail++; $display("FAIL skip_hold_rate50: got %0d/%b expected %0d/1", dbg_state, enable_hitskip, ST_SKIPPING);
      end
      n_tests++;
      if (skip_count !== 16'd0) begin n_fail++; $display("FAIL skipn0_no_drops: got %0d expected 0", skip_count); end
   endtask

   task automatic test_skip_ratio();
      logic [0:0] exp_q[$];
      logic [0:0] exp_v;
      for (int i = 0; i < 100; i++) exp_q.push_back(((i % 4) == 0) ? 1'b1 : 1'b0);
      cfg_write(2'd0, 16'h0031, 1'b0);
      for (int i = 0; i < 100; i++) begin
         hit_valid = 1'b1;
         tick();
         exp_v = exp_q.pop_front();
         n_tests++;
         if (hit_accept !== exp_v) begin
            n_fail++; $display("FAIL ratio_accept[%0d]: got %b expected %b", i, hit_accept, exp_v);
         end
      end
      hit_valid = 1'b0;
      n_tests++;
      if (skip_count !== 16'd75) begin n_fail++; $display("FAIL ratio_skip_count: got %0d expected 75", skip_count); end
      n_tests++;
      if (dbg_state !== ST_SKIPPING) begin n_fail++; $display("FAIL ratio_state: got %0d expected %0d", dbg_state, ST_SKIPPING); end
   endtask

   task automatic test_hysteresis();
      run_window(10, 1'b0);
      n_tests++;
      if ({dbg_state, enable_hitskip} !== {ST_MONITOR, 1'b1}) begin
         n_fail++; $display("FAIL low_rate_exit: got %0d/%b expected %0d/1", dbg_state, enable_hitskip, ST_MONITOR);
      end
      n_tests++;
      if (skip_count !== 16'd82) begin n_fail++; $display("FAIL low_rate_drops: got %0d expected 82", skip_count); end
      run_window(30, 1'b0);
      n_tests++;
      if (first_ehs !== 1'b0) begin n_fail++; $display("FAIL ehs_fall: got %b expected 0", first_ehs); end
      n_tests++;
      if (dbg_state !== ST_MONITOR) begin n_fail++; $display("FAIL band_hold_monitor: got %0d expected %0d", dbg_state, ST_MONITOR); end
      run_window(50, 1'b0);
      n_tests++;
      if (dbg_state !== ST_SKIPPING) begin n_fail++; $display("FAIL reenter_skip: got %0d expected %0d", dbg_state, ST_SKIPPING); end
      run_window(30, 1'b0);
      n_tests++;
      if (first_ehs !== 1'b1) begin n_fail++; $display("FAIL reenter_ehs: got %b expected 1", first_ehs); end
      n_tests++;
      if (dbg_state !== ST_SKIPPING) begin n_fail++; $display("FAIL band_hold_skipping: got %0d expected %0d", dbg_state, ST_SKIPPING); end
   endtask

   task automatic test_boundary();
      run_window(0, 1'b0);
      n_tests++;
      if (dbg_state !== ST_MONITOR) begin n_fail++; $display("FAIL zero_rate_exit: got %0d expected %0d", dbg_state, ST_MONITOR); end
      run_window(39, 1'b0);
      n_tests++;
      if (dbg_state !== ST_MONITOR) begin n_fail++; $display("FAIL below_on_39: got %0d expected %0d", dbg_state, ST_MONITOR); end
      run_window(39, 1'b1);
      n_tests++;
      if (dbg_state !== ST_SKIPPING) begin n_fail++; $display("FAIL last_cycle_hit_40: got %0d expected %0d", dbg_state, ST_SKIPPING); end
      run_window(0, 1'b0);
      // 50 hits, then a write that restarts the window, then 40 hits in the new window
      for (int i = 0; i < 50; i++) begin
         hit_valid = 1'b1;
         tick();
      end
      cfg_write(2'd3, 16'd20, 1'b0);
      for (int j = 1; j <= 100; j++) begin
         hit_valid = (j <= 40);
         tick();
         if (j == 49 || j == 99) begin
            n_tests++;
            if (dbg_state !== ST_MONITOR) begin
               n_fail++; $display("FAIL restart_no_transition[%0d]: got %0d expected %0d", j, dbg_state, ST_MONITOR);
            end
         end
         if (j == 100) begin
            n_tests++;
            if (dbg_state !== ST_SKIPPING) begin
               n_fail++; $display("FAIL restart_new_window_end: got %0d expected %0d", dbg_state, ST_SKIPPING);
            end
         end
      end
      hit_valid = 1'b0;
   endtask

   task automatic test_force_clear();
      cfg_write(2'd0, 16'h0000, 1'b0);
      tick();
      tick();
      n_tests++;
      if ({dbg_state, enable_hitskip} !== {ST_IDLE, 1'b0}) begin
         n_fail++; $display("FAIL en0_idle: got %0d/%b expected %0d/0", dbg_state, enable_hitskip, ST_IDLE);
      end
      cfg_write(2'd0, 16'h0003, 1'b0);
      tick();
      n_tests++;
      if (enable_hitskip !== 1'b1) begin n_fail++; $display("FAIL force_ehs: got %b expected 1", enable_hitskip); end
      cfg_write(2'd0, 16'h0033, 1'b0);
      for (int i = 0; i < 3; i++) begin
         hit_valid = 1'b1;
         tick();
         n_tests++;
         if (hit_accept !== (i == 0)) begin
            n_fail++; $display("FAIL force_ratio[%0d]: got %b expected %b", i, hit_accept, (i == 0));
         end
      end
      // drop and clear on the same edge: clear wins
      cfg_write(2'd0, 16'h8033, 1'b1);
      n_tests++;
      if ({hit_accept, skip_count} !== {1'b0, 16'd0}) begin
         n_fail++; $display("FAIL clear_vs_drop: got %b/%0d expected 0/0", hit_accept, skip_count);
      end
      hit_valid = 1'b1;
      tick();
      n_tests++;
      if ({hit_accept, skip_count} !== {1'b1, 16'd0}) begin
         n_fail++; $display("FAIL after_clear_pass: got %b/%0d expected 1/0", hit_accept, skip_count);
      end
      tick();
      n_tests++;
      if ({hit_accept, skip_count} !== {1'b0, 16'd1}) begin
         n_fail++; $display("FAIL after_clear_drop: got %b/%0d expected 0/1", hit_accept, skip_count);
      end
   endtask

   task automatic test_async_reset();
      #2 rst_n = 1'b0;
      #1;
      n_tests++;
      if ({hit_accept, enable_hitskip, cfg_ack, skip_count, dbg_state} !== {3'b000, 16'd0, ST_IDLE}) begin
         n_fail++; $display("FAIL async_reset: got %b%b%b/%0d/%0d expected 000/0/0",
                            hit_accept, enable_hitskip, cfg_ack, skip_count, dbg_state);
      end
      hit_valid = 1'b1;
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_tests++;
         if ({hit_accept, enable_hitskip, dbg_state} !== {1'b1, 1'b0, ST_IDLE}) begin
            n_fail++; $display("FAIL post_reset_ctrl[%0d]: got %b/%b/%0d expected 1/0/0", i, hit_accept, enable_hitskip, dbg_state);
         end
      end
      hit_valid = 1'b0;
      // default WINDOW=1000 and THRESH_ON=100
      cfg_write(2'd0, 16'h0001, 1'b0);
      tick();
      for (int j = 1; j <= 1000; j++) begin
         hit_valid = (j <= 100);
         tick();
         if (j == 999) begin
            n_tests++;
            if (dbg_state !== ST_MONITOR) begin n_fail++; $display("FAIL default_window_999: got %0d expected %0d", dbg_state, ST_MONITOR); end
         end
         if (j == 1000) begin
            n_tests++;
            if (dbg_state !== ST_SKIPPING) begin n_fail++; $display("FAIL default_window_1000: got %0d expected %0d", dbg_state, ST_SKIPPING); end
         end
      end
      hit_valid = 1'b0;
   endtask

   task automatic test_window_zero();
      cfg_write(2'd0, 16'h0000, 1'b0);
      cfg_write(2'd2, 16'd1, 1'b0);
      cfg_write(2'd3, 16'd1, 1'b0);
      cfg_write(2'd1, 16'd0, 1'b0);
      cfg_write(2'd0, 16'h0001, 1'b0);
      tick();
      n_tests++;
      if (dbg_state !== ST_MONITOR) begin n_fail++; $display("FAIL w0_monitor: got %0d expected %0d", dbg_state, ST_MONITOR); end
      hit_valid = 1'b1;
      tick();
      n_tests++;
      if (dbg_state !== ST_SKIPPING) begin n_fail++; $display("FAIL w0_one_hit: got %0d expected %0d", dbg_state, ST_SKIPPING); end
      hit_valid = 1'b0;
      tick();
      n_tests++;
      if (dbg_state !== ST_MONITOR) begin n_fail++; $display("FAIL w0_no_hit: got %0d expected %0d", dbg_state, ST_MONITOR); end
   endtask

   initial begin
      test_reset();
      test_transparent();
      test_enter_skip();
      test_skip_ratio();
      test_hysteresis();
      test_boundary();
      test_force_clear();
      test_async_reset();
      test_window_zero();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
